// File: rtl/lsnn_pkg.sv
// Shared types and helpers for the time-multiplexed LSNN neuron scheduler.
package lsnn_pkg;

    localparam int W_DEFAULT = 8;
    // Widest operand the saturating adder handles; datapaths up to 16 bits.
    localparam int SAT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        UPDATE,
        DONE
    } state_t;

    // Unsigned add, clamped to max_val instead of wrapping.
    function automatic logic [SAT_W-1:0] sat_add(
        input logic [SAT_W-1:0] a,
        input logic [SAT_W-1:0] b,
        input logic [SAT_W-1:0] max_val
    );
        logic [SAT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s > {1'b0, max_val}) begin
            return max_val;
        end
        return s[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/lsnn_lif_update.sv
// Combinational leaky integrate-and-fire update with adaptive threshold.
module lsnn_lif_update
    import lsnn_pkg::*;
#(
    parameter int             W               = W_DEFAULT,
    parameter int             LEAK_SHIFT      = 2,
    parameter logic [W-1:0]   THR_BASE        = 8'h40,
    parameter logic [W-1:0]   THR_INC         = 8'h10,
    parameter int             THR_DECAY_SHIFT = 3,
    parameter int             REFRAC          = 2,
    parameter int             RW              = 2
) (
    input  logic [W-1:0]  mem,
    input  logic [W-1:0]  thr,
    input  logic [RW-1:0] refrac,
    input  logic [W-1:0]  cur,
    output logic [W-1:0]  mem_nxt,
    output logic [W-1:0]  thr_nxt,
    output logic [RW-1:0] refrac_nxt,
    output logic          spike
);

    localparam logic [W-1:0] MAX_VAL = '1;

    logic [W-1:0] leaked;
    logic [W-1:0] sum;
    logic [W-1:0] decay_amt;
    logic [W-1:0] thr_decayed;
    logic [W-1:0] thr_bumped;

    // Leak, integrate, fire/refractory decision and threshold adaptation.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
        mem_nxt    = mem;
        thr_nxt    = thr;
        refrac_nxt = refrac;
        spike      = 1'b0;

        leaked = mem - (mem >> LEAK_SHIFT);
        sum    = W'(sat_add(SAT_W'(leaked), SAT_W'(cur), SAT_W'(MAX_VAL)));

        // Decay moves at least one step so thr always reaches THR_BASE eventually.
        decay_amt = (thr - THR_BASE) >> THR_DECAY_SHIFT;
        if (decay_amt == '0) begin
            decay_amt = W'(1);
        end
        thr_decayed = (thr > THR_BASE) ? (thr - decay_amt) : thr;
        thr_bumped  = W'(sat_add(SAT_W'(thr), SAT_W'(THR_INC), SAT_W'(MAX_VAL)));

        if (refrac != '0) begin
            mem_nxt    = '0;
            refrac_nxt = refrac - RW'(1);
            thr_nxt    = thr_decayed;
        end else if (sum >= thr) begin
            spike      = 1'b1;
            mem_nxt    = '0;
            thr_nxt    = thr_bumped;
            refrac_nxt = RW'(REFRAC);
        end else begin
            mem_nxt = sum;
            thr_nxt = thr_decayed;
        end
    end

endmodule

// File: rtl/lsnn_neuron_scheduler.sv
// Time-multiplexes one LIF datapath across N_NEURONS virtual neurons.
module lsnn_neuron_scheduler
    import lsnn_pkg::*;
#(
    parameter int           N_NEURONS       = 4,
    parameter int           W               = W_DEFAULT,
    parameter int           LEAK_SHIFT      = 2,
    parameter logic [W-1:0] THR_BASE        = 8'h40,
    parameter logic [W-1:0] THR_INC         = 8'h10,
    parameter int           THR_DECAY_SHIFT = 3,
    parameter int           REFRAC          = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         step_start,
    output logic                         cur_req,
    output logic [$clog2(N_NEURONS)-1:0] cur_idx,
    input  logic                         cur_valid,
    input  logic [W-1:0]                 cur_in,
    output logic                         spike_valid,
    output logic [$clog2(N_NEURONS)-1:0] spike_idx,
    output logic                         spike,
    output logic [W-1:0]                 thr_out,
    output logic                         busy,
    output logic                         done
);

    localparam int IW = $clog2(N_NEURONS);
    localparam int RW = (REFRAC < 1) ? 1 : $clog2(REFRAC + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_NEURONS - 1);

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q;
    logic [W-1:0]  cur_lat_q;
    logic [W-1:0]  mem_q    [N_NEURONS];
    logic [W-1:0]  thr_q    [N_NEURONS];
    logic [RW-1:0] refrac_q [N_NEURONS];

    logic [W-1:0]  mem_nxt;
    logic [W-1:0]  thr_nxt;
    logic [RW-1:0] refrac_nxt;
    logic          spike_nxt;

    lsnn_lif_update #(
        .W               (W),
        .LEAK_SHIFT      (LEAK_SHIFT),
        .THR_BASE        (THR_BASE),
        .THR_INC         (THR_INC),
        .THR_DECAY_SHIFT (THR_DECAY_SHIFT),
        .REFRAC          (REFRAC),
        .RW              (RW)
    ) u_lif (
        .mem        (mem_q[idx_q]),
        .thr        (thr_q[idx_q]),
        .refrac     (refrac_q[idx_q]),
        .cur        (cur_lat_q),
        .mem_nxt    (mem_nxt),
        .thr_nxt    (thr_nxt),
        .refrac_nxt (refrac_nxt),
        .spike      (spike_nxt)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and handshake/report outputs.
    always_comb begin
        state_d     = state_q;
        cur_req     = 1'b0;
        spike_valid = 1'b0;
        spike       = 1'b0;
        thr_out     = '0;
        busy        = (state_q != IDLE);
        done        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (step_start) state_d = REQ;
            end
            REQ: begin
                cur_req = 1'b1;
                if (cur_valid) state_d = UPDATE;
            end
            UPDATE: begin
                spike_valid = 1'b1;
                spike       = spike_nxt;
                thr_out     = thr_nxt;
                state_d     = (idx_q == LAST_IDX) ? DONE : REQ;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cur_idx   = idx_q;
    assign spike_idx = idx_q;

    // Neuron index walk and current capture on the request handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= '0;
            cur_lat_q <= '0;
        end else begin
            if (state_q == IDLE && step_start) begin
                idx_q <= '0;
            end else if (state_q == UPDATE && idx_q != LAST_IDX) begin
                idx_q <= idx_q + IW'(1);
            end
            if (state_q == REQ && cur_valid) begin
                cur_lat_q <= cur_in;
            end
        end
    end

    // Per-neuron state file, written back once per neuron update.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: this state file is reset because neurons must start from rest after an aborted step; it is small enough to live in flops.
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                mem_q[i]    <= '0;
                thr_q[i]    <= THR_BASE;
                refrac_q[i] <= '0;
            end
        end else if (state_q == UPDATE) begin
            mem_q[idx_q]    <= mem_nxt;
            thr_q[idx_q]    <= thr_nxt;
            refrac_q[idx_q] <= refrac_nxt;
        end
    end

endmodule

// File: tb/tb_lsnn_neuron_scheduler.sv
// Self-checking bench for lsnn_neuron_scheduler: scoreboard of per-neuron
// updates fed by an independent behavioural model, plus timing corner cases.
module tb_lsnn_neuron_scheduler;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       step_start = 1'b0;
    logic       cur_valid = 1'b0;
    logic [7:0] cur_in;
    logic       cur_req;
    logic [1:0] cur_idx;
    logic       spike_valid;
    logic [1:0] spike_idx;
    logic       spike;
    logic [7:0] thr_out;
    logic       busy;
    logic       done;

    logic [7:0] cur_vec [N];
    assign cur_in = cur_vec[cur_idx];

    lsnn_neuron_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .step_start  (step_start),
        .cur_req     (cur_req),
        .cur_idx     (cur_idx),
        .cur_valid   (cur_valid),
        .cur_in      (cur_in),
        .spike_valid (spike_valid),
        .spike_idx   (spike_idx),
        .spike       (spike),
        .thr_out     (thr_out),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int p0       = 0;
    int stall_cycles = 0;
    int n_sv     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] idx;
        logic       sp;
        logic [7:0] thr;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    typedef struct packed {
        logic [7:0] c0, c1, c2, c3;
        logic       sp0;
        logic [7:0] thr0;
    } vec_t;
    vec_t tbl [5];

    logic       last_sp0;
    logic [7:0] last_thr0;

    int m_mem [N];
    int m_thr [N];
    int m_ref [N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_mem[i] = 0;
            m_thr[i] = 64;
            m_ref[i] = 0;
        end
    endtask

    function automatic int decayed(input int t);
        int d;
        if (t <= 64) return t;
        d = (t - 64) / 8;
        if (d == 0) d = 1;
        return t - d;
    endfunction

    task automatic model_step(input int i, input int cur, output int sp, output int th);
        int leaked, s;
        leaked = m_mem[i] - m_mem[i] / 4;
        sp = 0;
        if (m_ref[i] > 0) begin
            m_mem[i] = 0;
            m_ref[i] = m_ref[i] - 1;
            m_thr[i] = decayed(m_thr[i]);
        end else begin
            s = leaked + cur;
            if (s > 255) s = 255;
            if (s >= m_thr[i]) begin
                sp = 1;
                m_mem[i] = 0;
                m_thr[i] = (m_thr[i] + 16 > 255) ? 255 : m_thr[i] + 16;
                m_ref[i] = 2;
            end else begin
                m_mem[i] = s;
                m_thr[i] = decayed(m_thr[i]);
            end
        end
        th = m_thr[i];
    endtask

    task automatic push_step(input logic [7:0] c0, c1, c2, c3);
        int   sp, th;
        exp_t x;
        cur_vec[0] = c0;
        cur_vec[1] = c1;
        cur_vec[2] = c2;
        cur_vec[3] = c3;
        for (int i = 0; i < N; i++) begin
            model_step(i, int'(cur_vec[i]), sp, th);
            x.idx = 2'(i);
            x.sp  = sp[0];
            x.thr = th[7:0];
            sb.push_back(x);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        step_start = 1'b1;
        @(negedge clk);
        step_start = 1'b0;
        p0 = cyc;
        check("busy_in_step", busy, 1);
    endtask

    // One full timestep: optional stall on neuron 0, optional step_start pokes while busy.
    task automatic run_step(input logic [7:0] c0, c1, c2, c3, input int stall, input bit poke);
        bit seen;
        int lat;
        push_step(c0, c1, c2, c3);
        stall_cycles = stall;
        cur_valid = (stall == 0);
        pulse_start();
        if (stall > 0) begin
            repeat (stall) begin
                @(negedge clk);
                check("cur_req_held_in_stall", cur_req, 1);
                check("no_update_in_stall", spike_valid, 0);
            end
            cur_valid = 1'b1;
        end
        seen = 1'b0;
        lat  = -1;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                lat  = cyc + 1 - p0;
            end
            if (poke) step_start = (cyc == p0 + 2) || done;
        end
        check("done_seen", seen, 1);
        if (seen) check("done_latency", lat, 2 * N + 1 + stall);
        @(negedge clk);
        step_start = 1'b0;
        check("idle_after_done", busy, 0);
        check("done_one_cycle", done, 0);
        check("no_req_after_done", cur_req, 0);
        check("scoreboard_drained", sb.size(), 0);
    endtask

    // Scoreboard consumer: every update pulse must match the next expected record.
    always @(negedge clk) begin
        if (rst_n && spike_valid) begin
            n_sv++;
            if (sb.size() == 0) begin
                check("unexpected_spike_valid", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("spike_idx", spike_idx, mon_e.idx);
                check("spike", spike, mon_e.sp);
                check("thr_out", thr_out, mon_e.thr);
                check("update_latency", cyc + 1 - p0, 2 + 2 * int'(mon_e.idx) + stall_cycles);
                check("thr_not_below_base", thr_out >= 8'h40, 1);
                if (spike_idx == 2'd0) begin
                    last_sp0  = spike;
                    last_thr0 = thr_out;
                end
            end
        end
    end

    initial begin
        bit found;
        int sv_before;

        tbl[0] = '{8'h30, 8'h00, 8'h40, 8'h3F, 1'b0, 8'h40};
        tbl[1] = '{8'h30, 8'h10, 8'h00, 8'h00, 1'b1, 8'h50};
        tbl[2] = '{8'hFF, 8'h00, 8'h00, 8'h20, 1'b0, 8'h4E};
        tbl[3] = '{8'hFF, 8'h00, 8'h05, 8'h00, 1'b0, 8'h4D};
        tbl[4] = '{8'hFF, 8'h00, 8'h00, 8'h00, 1'b1, 8'h5D};

        for (int i = 0; i < N; i++) cur_vec[i] = 8'h00;
        model_reset();

        // Reset state.
        #12;
        check("rst_busy", busy, 0);
        check("rst_cur_req", cur_req, 0);
        check("rst_spike_valid", spike_valid, 0);
        check("rst_spike", spike, 0);
        check("rst_done", done, 0);
        check("rst_cur_idx", cur_idx, 0);
        check("rst_spike_idx", spike_idx, 0);
        check("rst_thr_out", thr_out, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven steps: neuron 0 integrates, fires, goes refractory, fires again.
        for (int v = 0; v < 5; v++) begin
            last_sp0  = 1'bx;
            last_thr0 = 8'hxx;
            run_step(tbl[v].c0, tbl[v].c1, tbl[v].c2, tbl[v].c3, 0, 1'b0);
            check("table_neuron0_spike", last_sp0, tbl[v].sp0);
            check("table_neuron0_thr", last_thr0, tbl[v].thr0);
        end

        // Neuron 0 current withheld for 5 cycles.
        run_step(8'h10, 8'h20, 8'h30, 8'h00, 5, 1'b0);

        // step_start pulsed mid-step and during DONE must be ignored.
        run_step(8'h00, 8'h44, 8'h00, 8'h11, 0, 1'b1);

        // Neuron 1 driven hard every step: thr adapts without wrapping.
        for (int s = 0; s < 12; s++) begin
            run_step(8'($urandom_range(0, 8'h50)), 8'hFF,
                     8'($urandom_range(0, 8'hFF)), 8'($urandom_range(0, 8'h3F)), 0, 1'b0);
        end

        // Reset while neuron 2 is waiting for its current.
        push_step(8'h20, 8'h20, 8'h20, 8'h20);
        stall_cycles = 0;
        cur_valid = 1'b1;
        pulse_start();
        found = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (cur_req && cur_idx == 2'd2) begin
                found = 1'b1;
                break;
            end
        end
        check("reached_req_neuron2", found, 1);
        cur_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_cur_req", cur_req, 0);
        check("abort_spike_valid", spike_valid, 0);
        check("abort_cur_idx", cur_idx, 0);
        sb.delete();
        model_reset();
        sv_before = n_sv;
        cur_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("no_update_in_reset", n_sv - sv_before, 0);
        check("no_done_in_reset", done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_abort", busy, 0);

        // Fresh step after abort: everything starts from rest.
        run_step(8'h3F, 8'h3F, 8'h00, 8'h40, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard bound on total run time.
    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "global timeout");
    end

endmodule
